// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
//   Conditions one front-panel push button. The raw pad goes through a
//   two-flop synchroniser and a debouncer. The stable level then drives a
//   small hold FSM that emits single-cycle press / release / long-press /
//   auto-repeat events. Use one instance per key.
//
// Optional feature (macro KEY_AUTO_REPEAT_EN):
//   defined   - LONG state emits repeat_pulse every REPEAT_CYCLES
//   undefined - repeat_pulse is tied low and the hold counter parks in LONG
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   key_in        in   raw pad, active-high, asynchronous, may bounce
//   key_level     out  debounced, registered key level
//   press_pulse   out  one-cycle pulse on debounced press
//   release_pulse out  one-cycle pulse on debounced release
//   long_pulse    out  one-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse  out  one-cycle pulse every REPEAT_CYCLES after long_pulse
//   held          out  high while the FSM is outside IDLE
// ---------------------------------------------------------------------------
module key_event_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t            state_q;
    logic              s1_q, s2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q;
    logic              level_d;
    logic              rise, fall;

    // Debounce next state. The level flips on the same edge the counter
    // would otherwise pass its terminal value, so the FSM can react to the
    // new level in that same cycle and its pulses line up with key_level.
    always_comb begin
        db_cnt_d = '0;
        level_d  = key_level;
        if (s2_q != key_level) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~key_level;
    assign fall = ~level_d & key_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            db_cnt_q      <= '0;
            key_level     <= 1'b0;
            hold_q        <= '0;
            state_q       <= IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            held          <= 1'b0;
        end else begin
            s1_q          <= key_in;
            s2_q          <= s1_q;
            db_cnt_q      <= db_cnt_d;
            key_level     <= level_d;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        hold_q      <= '0;
                        state_q     <= PRESSED;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over long_pulse.
                    if (fall) begin
                        release_pulse <= 1'b1;
                        hold_q        <= '0;
                        state_q       <= IDLE;
                        held          <= 1'b0;
                    end else if (hold_q == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        hold_q     <= '0;
                        state_q    <= LONG;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        release_pulse <= 1'b1;
                        hold_q        <= '0;
                        state_q       <= IDLE;
                        held          <= 1'b0;
                    end
`ifdef KEY_AUTO_REPEAT_EN
                    else if (hold_q == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        hold_q       <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end
                default: begin
                    hold_q  <= '0;
                    state_q <= IDLE;
                    held    <= 1'b0;
                end
            endcase
        end
    end

`ifndef KEY_AUTO_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
module tb_key_event_decoder;

    localparam logic [3:0] EV_PRESS = 4'b0001;
    localparam logic [3:0] EV_REL   = 4'b0010;
    localparam logic [3:0] EV_LONG  = 4'b0100;
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [3:0] EV_REP   = 4'b1000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
        logic       hd;
        logic       lv;
    } exp_t;

    exp_t q[$];

    key_event_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] ev, input logic hd, input logic lv);
        exp_t x;
        x.cyc = c; x.ev = ev; x.hd = hd; x.lv = lv;
        q.push_back(x);
    endtask

    task automatic check_all_zero(input string name);
        logic [5:0] act;
        act = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        checks++;
        if (act != 6'b0) begin
            failures++;
            $display("FAIL %s outputs=%b expected=000000", name, act);
        end
    endtask

    // Monitor: every event pulse pops the next expectation; an expectation
    // whose cycle passes with no pulse is reported as missed.
    always @(negedge clk) begin
        logic [3:0] act;
        exp_t x;
        act = {repeat_pulse, long_pulse, release_pulse, press_pulse};
        if (act != 4'b0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d ev=%b", edge_n, act);
            end else begin
                x = q.pop_front();
                if (x.cyc != edge_n || x.ev != act || x.hd != held || x.lv != key_level) begin
                    failures++;
                    $display("FAIL event got cyc=%0d ev=%b held=%b level=%b, expected cyc=%0d ev=%b held=%b level=%b",
                             edge_n, act, held, key_level, x.cyc, x.ev, x.hd, x.lv);
                end
            end
        end else if (q.size() != 0 && q[0].cyc <= edge_n) begin
            x = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event at cyc=%0d ev=none, expected cyc=%0d ev=%b", edge_n, x.cyc, x.ev);
        end
    end

    initial begin
        int e, p;
        rst    = 1'b1;
        key_in = 1'b0;
        step(3);
        check_all_zero("reset_state");
        rst = 1'b0;
        step(4);

        // Clean press, held long (with a short low glitch), then release.
        key_in = 1'b1; e = edge_n; p = e + 6;
        push(p, EV_PRESS, 1'b1, 1'b1);
        push(p + 10, EV_LONG, 1'b1, 1'b1);
`ifdef KEY_AUTO_REPEAT_EN
        for (int k = 13; k <= 34; k += 3) push(p + k, EV_REP, 1'b1, 1'b1);
`endif
        step(8);
        key_in = 1'b0; step(3); key_in = 1'b1;
        step(p + 30 - edge_n);
        key_in = 1'b0;
        push(edge_n + 6, EV_REL, 1'b0, 1'b0);
        step(12);

        // Bounce 1,0,1,0 then settle high for 8 cycles.
        key_in = 1'b1; step(1);
        key_in = 1'b0; step(1);
        key_in = 1'b1; step(1);
        key_in = 1'b0; step(1);
        key_in = 1'b1; e = edge_n;
        push(e + 6, EV_PRESS, 1'b1, 1'b1);
        step(8);
        key_in = 1'b0;
        push(e + 14, EV_REL, 1'b0, 1'b0);
        step(12);

        // Short press: 8 stable cycles, no long_pulse.
        key_in = 1'b1; e = edge_n;
        push(e + 6, EV_PRESS, 1'b1, 1'b1);
        step(8);
        key_in = 1'b0;
        push(e + 14, EV_REL, 1'b0, 1'b0);
        step(12);

        // Release lands on the long-press boundary: release wins.
        key_in = 1'b1; e = edge_n;
        push(e + 6, EV_PRESS, 1'b1, 1'b1);
        step(10);
        key_in = 1'b0;
        push(e + 16, EV_REL, 1'b0, 1'b0);
        step(12);

        // Reset while in LONG with the key still down.
        key_in = 1'b1; e = edge_n;
        push(e + 6, EV_PRESS, 1'b1, 1'b1);
        push(e + 16, EV_LONG, 1'b1, 1'b1);
        step(18);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_hold");
        step(3);
        rst = 1'b0; e = edge_n;
        push(e + 6, EV_PRESS, 1'b1, 1'b1);
        step(8);
        key_in = 1'b0;
        push(edge_n + 6, EV_REL, 1'b0, 1'b0);
        step(12);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events left=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
